// File: rtl/if_prefetch_buffer_if.sv
// ----------------------------------------------------------------------------
// if_prefetch_buffer_if
// Bus bundle for the instruction prefetch buffer.
//   Memory side : instr_req / instr_addr (out), instr_gnt / instr_rvalid /
//                 instr_rdata (in) -- pipelined req/gnt, in-order rvalid.
//   IF side     : valid / rdata / addr (out), ready (in) -- head entry
//                 consumed on valid & ready.
//   Status      : busy (out) -- request pending or responses outstanding.
// Modports:
//   master : the prefetch buffer (drives requests and the IF-side head).
//   slave  : the environment (memory + IF stage).
// ----------------------------------------------------------------------------
interface if_prefetch_buffer_if;
    logic        instr_req;
    logic        instr_gnt;
    logic [31:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        valid;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        ready;
    logic        busy;

    modport master (
        output instr_req, instr_addr, valid, rdata, addr, busy,
        input  instr_gnt, instr_rvalid, instr_rdata, ready
    );

    modport slave (
        input  instr_req, instr_addr, valid, rdata, addr, busy,
        output instr_gnt, instr_rvalid, instr_rdata, ready
    );
endinterface

// File: rtl/if_prefetch_buffer.sv
// ----------------------------------------------------------------------------
// if_prefetch_buffer
// Instruction fetch front-end between the instruction memory port and the IF
// stage. Issues pipelined req/gnt/rvalid fetches (at most MAX_OUTSTANDING in
// flight) into a FIFO_DEPTH-entry buffer, redirects on branch while dropping
// stale responses, and hands (instr, pc) pairs to IF under valid/ready.
//
// Ports:
//   clk_i           clock
//   rst_ni          synchronous active-low reset
//   fetch_enable_i  permit issuing new requests
//   boot_addr_i     fetch address loaded at reset (word aligned internally)
//   branch_i        redirect pulse
//   branch_addr_i   redirect target (word aligned internally)
//   bus             if_prefetch_buffer_if.master: memory req/gnt/rvalid port,
//                   IF-side valid/rdata/addr/ready, busy status
//
// Build option:
//   PREFETCH_BYPASS_EN  when defined, a response arriving while the buffer is
//                       empty is presented on valid/rdata/addr in the same
//                       cycle, and is not stored if IF takes it immediately.
//                       When undefined, all outputs come straight from flops.
// ----------------------------------------------------------------------------
module if_prefetch_buffer #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 fetch_enable_i,
    input  logic [31:0]          boot_addr_i,
    input  logic                 branch_i,
    input  logic [31:0]          branch_addr_i,
    if_prefetch_buffer_if.master bus
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e            state_q, state_d;
    logic [31:0]       instr_addr_q, instr_addr_d;
    logic [31:0]       fetch_addr_q, fetch_addr_d;  // next address not yet issued
    logic [31:0]       resp_pc_q, resp_pc_d;
    logic [OutW-1:0]   out_q, out_d;
    logic [OutW-1:0]   discard_q, discard_d;
    logic              stale_q, stale_d;            // pending req predates a branch
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [31:0]       instr_mem_q [FIFO_DEPTH];
    logic [31:0]       pc_mem_q    [FIFO_DEPTH];

    logic [31:0]       boot_aligned;
    logic [31:0]       branch_tgt;
    logic [31:0]       fetch_cur;
    logic              gnt_ok;
    logic              rvalid_ok;
    logic              accept;
    logic              empty;
    logic              bypass_take;
    logic              push;
    logic              pop;
    logic              allowed;
    logic              issue;

    assign boot_aligned = boot_addr_i & 32'hFFFF_FFFC;
    assign branch_tgt   = branch_addr_i & 32'hFFFF_FFFC;

    assign gnt_ok    = (state_q == StReq) & bus.instr_gnt;
    // rvalid with nothing in flight (e.g. a response to a pre-reset request) is spurious.
    assign rvalid_ok = bus.instr_rvalid & (out_q != '0);
    // Responses in the branch cycle, or still owed to a discarded stream, are dropped.
    assign accept    = rvalid_ok & ~branch_i & (discard_q == '0);
    assign empty     = (count_q == '0);

`ifdef PREFETCH_BYPASS_EN
    assign bypass_take = empty & accept & bus.ready;
    assign bus.valid   = ~empty | accept;
    assign bus.rdata   = empty ? bus.instr_rdata : instr_mem_q[rptr_q];
    assign bus.addr    = empty ? resp_pc_q : pc_mem_q[rptr_q];
`else
    assign bypass_take = 1'b0;
    assign bus.valid   = ~empty;
    assign bus.rdata   = instr_mem_q[rptr_q];
    assign bus.addr    = pc_mem_q[rptr_q];
`endif

    assign push = accept & ~bypass_take;
    assign pop  = ~empty & bus.ready & ~branch_i;

    assign bus.instr_req  = (state_q == StReq);
    assign bus.instr_addr = instr_addr_q;
    assign bus.busy       = bus.instr_req | (out_q != '0);

    // Outstanding / discard / buffer bookkeeping.
    always_comb begin
        out_d     = out_q + OutW'(gnt_ok) - OutW'(rvalid_ok);
        discard_d = discard_q;
        stale_d   = stale_q;
        count_d   = count_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        resp_pc_d = resp_pc_q;

        if (branch_i) begin
            // Everything still in flight after this edge belongs to the old stream.
            discard_d = out_d;
            stale_d   = (state_q == StReq) & ~bus.instr_gnt;
            count_d   = '0;
            rptr_d    = '0;
            wptr_d    = '0;
            resp_pc_d = branch_tgt;
        end else begin
            discard_d = discard_q - OutW'(rvalid_ok & (discard_q != '0))
                                  + OutW'(gnt_ok & stale_q);
            if (gnt_ok) begin
                stale_d = 1'b0;
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
            wptr_d  = wptr_q + PtrW'(push);
            rptr_d  = rptr_q + PtrW'(pop);
            if (accept) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
        end
    end

    // Request FSM. Credit is judged on next-cycle occupancy so a response can
    // never find the buffer full.
    always_comb begin
        fetch_cur    = branch_i ? branch_tgt : fetch_addr_q;
        allowed      = fetch_enable_i
                     & (32'(out_d) < MAX_OUTSTANDING)
                     & ((32'(count_d) + 32'(out_d)) < FIFO_DEPTH);
        state_d      = state_q;
        instr_addr_d = instr_addr_q;
        fetch_addr_d = fetch_cur;
        issue        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (allowed) begin
                    issue = 1'b1;
                end
            end
            StReq: begin
                // An ungranted request is never withdrawn or re-addressed.
                if (bus.instr_gnt) begin
                    if (allowed) begin
                        issue = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            state_d      = StReq;
            instr_addr_d = fetch_cur;
            fetch_addr_d = fetch_cur + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            instr_addr_q <= '0;
            fetch_addr_q <= boot_aligned;
            resp_pc_q    <= boot_aligned;
            out_q        <= '0;
            discard_q    <= '0;
            stale_q      <= 1'b0;
            count_q      <= '0;
            rptr_q       <= '0;
            wptr_q       <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            instr_addr_q <= instr_addr_d;
            fetch_addr_q <= fetch_addr_d;
            resp_pc_q    <= resp_pc_d;
            out_q        <= out_d;
            discard_q    <= discard_d;
            stale_q      <= stale_d;
            count_q      <= count_d;
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            if (push) begin
                instr_mem_q[wptr_q] <= bus.instr_rdata;
                pc_mem_q[wptr_q]    <= resp_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_if_prefetch_buffer
// Scoreboard bench for if_prefetch_buffer (FIFO_DEPTH=4, MAX_OUTSTANDING=2).
// The main process drives directed scenarios and queues the hand-computed
// (instr, pc) pairs each scenario must deliver; a negedge monitor pops and
// compares on every valid & ready handshake. Memory returns {addr[15:0],C0DE}
// one cycle after grant, with a grant budget and a response hold control.
// ----------------------------------------------------------------------------
module tb_if_prefetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        fetch_enable;
    logic [31:0] boot_addr;
    logic        branch;
    logic [31:0] branch_addr;

    if_prefetch_buffer_if bus ();

    if_prefetch_buffer #(
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .fetch_enable_i (fetch_enable),
        .boot_addr_i    (boot_addr),
        .branch_i       (branch),
        .branch_addr_i  (branch_addr),
        .bus            (bus)
    );

    int          n_vec;
    int          n_fail;
    logic [63:0] exp_q [$];   // {rdata, addr}
    logic [31:0] pend_q [$];  // granted addresses awaiting rvalid
    int          budget;
    int          gnt_count;
    logic        resp_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    // Memory model: drives gnt/rvalid 1 time unit after each rising edge.
    initial begin
        bus.instr_gnt    = 1'b0;
        bus.instr_rvalid = 1'b0;
        bus.instr_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en && pend_q.size() > 0) begin
                bus.instr_rvalid = 1'b1;
                bus.instr_rdata  = mem_data(pend_q.pop_front());
            end else begin
                bus.instr_rvalid = 1'b0;
                bus.instr_rdata  = '0;
            end
            if (bus.instr_req && budget > 0) begin
                bus.instr_gnt = 1'b1;
                budget--;
                gnt_count++;
                pend_q.push_back(bus.instr_addr);
            end else begin
                bus.instr_gnt = 1'b0;
            end
        end
    end

    // Monitor: every handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && bus.valid && bus.ready && !branch) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_entry: got rdata=0x%08h addr=0x%08h, required none",
                         bus.rdata, bus.addr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (bus.rdata !== e[63:32] || bus.addr !== e[31:0]) begin
                    n_fail++;
                    $display("FAIL entry: got rdata=0x%08h addr=0x%08h, required rdata=0x%08h addr=0x%08h",
                             bus.rdata, bus.addr, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_entry(input logic [31:0] rdata, input logic [31:0] pc);
        exp_q.push_back({rdata, pc});
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
            step(1);
        end
        check(name, 32'(exp_q.size()), 32'd0);
        step(2);
    endtask

    task automatic pulse_branch(input logic [31:0] tgt);
        branch      = 1'b1;
        branch_addr = tgt;
        step(1);
        branch      = 1'b0;
    endtask

    int g0;

    initial begin
        n_vec        = 0;
        n_fail       = 0;
        budget       = 0;
        gnt_count    = 0;
        resp_en      = 1'b1;
        rst_n        = 1'b0;
        fetch_enable = 1'b0;
        boot_addr    = 32'h0000_0083;
        branch       = 1'b0;
        branch_addr  = '0;
        bus.ready    = 1'b0;

        // Reset state
        step(2);
        check("rst_req",   32'(bus.instr_req), 32'd0);
        check("rst_valid", 32'(bus.valid),     32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_rdata", bus.rdata,          32'h0);
        check("rst_addr",  bus.addr,           32'h0);

        // 1: sequential fetch from aligned boot address
        expect_entry(32'h0080_C0DE, 32'h0000_0080);
        expect_entry(32'h0084_C0DE, 32'h0000_0084);
        expect_entry(32'h0088_C0DE, 32'h0000_0088);
        expect_entry(32'h008C_C0DE, 32'h0000_008C);
        rst_n        = 1'b1;
        fetch_enable = 1'b1;
        bus.ready    = 1'b1;
        budget       = 4;
        begin
            int k;
            k = 0;
            while (!bus.instr_req && k < 10) begin
                step(1);
                k++;
            end
            check("first_req_addr", bus.instr_addr, 32'h0000_0080);
        end
        wait_drain("drain_seq", 40);

        // 3: ungranted request held stable after fetch_enable drops
        fetch_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("hold_req",  32'(bus.instr_req), 32'd1);
            check("hold_addr", bus.instr_addr,     32'h0000_0090);
        end
        expect_entry(32'h0090_C0DE, 32'h0000_0090);
        budget = 1;
        step(2);
        check("req_drop_after_gnt", 32'(bus.instr_req), 32'd0);
        check("busy_outstanding",   32'(bus.busy),      32'd1);
        wait_drain("drain_hold", 20);

        // 2: fill with ready low, then one pop buys exactly one more fetch
        bus.ready    = 1'b0;
        fetch_enable = 1'b1;
        g0           = gnt_count;
        budget       = 100;
        expect_entry(32'h0094_C0DE, 32'h0000_0094);
        expect_entry(32'h0098_C0DE, 32'h0000_0098);
        expect_entry(32'h009C_C0DE, 32'h0000_009C);
        expect_entry(32'h00A0_C0DE, 32'h0000_00A0);
        expect_entry(32'h00A4_C0DE, 32'h0000_00A4);
        step(20);
        check("full_grants", 32'(gnt_count - g0), 32'd4);
        check("full_req",    32'(bus.instr_req),  32'd0);
        check("full_valid",  32'(bus.valid),      32'd1);
        bus.ready = 1'b1;
        step(1);
        bus.ready = 1'b0;
        step(10);
        check("pop_grants", 32'(gnt_count - g0), 32'd5);
        check("pop_req",    32'(bus.instr_req),  32'd0);
        fetch_enable = 1'b0;
        budget       = 0;
        bus.ready    = 1'b1;
        wait_drain("drain_full", 30);

        // 5: address wrap at the top of memory
        fetch_enable = 1'b1;
        budget       = 3;
        expect_entry(32'hFFF8_C0DE, 32'hFFFF_FFF8);
        expect_entry(32'hFFFC_C0DE, 32'hFFFF_FFFC);
        expect_entry(32'h0000_C0DE, 32'h0000_0000);
        pulse_branch(32'hFFFF_FFF8);
        wait_drain("drain_wrap", 30);
        check("wrap_next_addr", bus.instr_addr, 32'h0000_0004);
        fetch_enable = 1'b0;
        expect_entry(32'h0004_C0DE, 32'h0000_0004);
        budget = 1;
        wait_drain("drain_wrap_tail", 20);

        // 4: branch with two responses outstanding drops both
        resp_en      = 1'b0;
        fetch_enable = 1'b1;
        budget       = 2;
        pulse_branch(32'h0000_0100);
        step(6);
        check("two_out_busy", 32'(bus.busy),      32'd1);
        check("two_out_req",  32'(bus.instr_req), 32'd0);
        expect_entry(32'h2000_C0DE, 32'h0000_2000);
        expect_entry(32'h2004_C0DE, 32'h0000_2004);
        resp_en = 1'b1;
        budget  = 2;
        pulse_branch(32'h0000_2002);
        wait_drain("drain_branch", 30);
        fetch_enable = 1'b0;
        expect_entry(32'h2008_C0DE, 32'h0000_2008);
        budget = 1;
        wait_drain("drain_branch_tail", 20);

        // 6: reset mid-burst with buffer half full and two outstanding
        bus.ready    = 1'b0;
        fetch_enable = 1'b1;
        budget       = 2;
        pulse_branch(32'h0000_0300);
        step(6);
        check("pre_rst_valid", 32'(bus.valid), 32'd1);
        resp_en = 1'b0;
        budget  = 2;
        step(5);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n        = 1'b0;
        fetch_enable = 1'b0;
        step(1);
        check("mid_rst_valid", 32'(bus.valid),     32'd0);
        check("mid_rst_busy",  32'(bus.busy),      32'd0);
        check("mid_rst_req",   32'(bus.instr_req), 32'd0);
        rst_n     = 1'b1;
        resp_en   = 1'b1;
        bus.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("late_rvalid_valid", 32'(bus.valid), 32'd0);
        end
        check("late_rvalid_busy", 32'(bus.busy), 32'd0);
        check("exp_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
